// File: rtl/psum_acc_if.sv
// Partial-sum accumulator handshake bundle: product beats in, drained map words out.
interface psum_acc_if #(
  parameter int word_length = 8,
  parameter int col_length  = 8,
  parameter int lanes       = 16,
  parameter int acc_width   = 24
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_last;
  logic [lanes*2*word_length-1:0]  data_in;
  logic [lanes*col_length-1:0]     data_in_cols;
  logic [lanes*col_length-1:0]     data_in_rows;
  logic                            out_valid;
  logic                            out_ready;
  logic [acc_width-1:0]            out_data;
  logic [col_length-1:0]           out_row;
  logic [col_length-1:0]           out_col;
  logic                            done;

  modport master (
    output in_valid, in_last, data_in, data_in_cols, data_in_rows, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, done
  );
  modport slave (
    input  in_valid, in_last, data_in, data_in_cols, data_in_rows, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, done
  );
endinterface

// File: rtl/psum_acc.sv
// Scatter-accumulates per-lane products into an out_size x out_size map, then drains it in raster order.
// Optional build macro PSUM_RELU_EN rectifies drained words (accumulator contents unaffected).
module psum_acc #(
  parameter int word_length = 8,
  parameter int col_length  = 8,
  parameter int lanes       = 16,
  parameter int out_size    = 24,
  parameter int acc_width   = 24
) (
  input  logic      clk,
  input  logic      rst,
  psum_acc_if.slave io
);
  localparam int PW   = 2*word_length;
  localparam int NENT = out_size*out_size;
  localparam int AW   = (NENT > 1) ? $clog2(NENT) : 1;
  localparam int LW   = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [col_length-1:0] EDGE      = col_length'(out_size-1);
  localparam logic [LW-1:0]         LAST_LANE = LW'(lanes-1);

  localparam logic [1:0] S_CLEAR = 2'd0, S_ACCUM = 2'd1, S_SCATTER = 2'd2, S_DRAIN = 2'd3;

  logic [1:0]                            state_q, state_d;
  logic [col_length-1:0]                 row_q, row_d, col_q, col_d;
  logic [LW-1:0]                         lane_q, lane_d;
  logic                                  done_q, done_d;
  logic [lanes-1:0][PW-1:0]              hold_data_q;
  logic [lanes-1:0][col_length-1:0]      hold_rows_q, hold_cols_q;
  logic                                  hold_last_q;
  logic signed [acc_width-1:0]           acc_q [NENT];

  logic                                  accept, raster_last, wr_en;
  logic [col_length-1:0]                 row_nx, col_nx;
  logic [AW-1:0]                         raster_addr, scat_addr, wr_addr;
  logic signed [acc_width-1:0]           wr_data, entry, drain_val;
  logic [lanes-1:0]                      lane_hit;
  logic signed [acc_width-1:0]           lane_ext [lanes];

  function automatic logic [AW-1:0] addr_of(input logic [col_length-1:0] r, input logic [col_length-1:0] c);
    return AW'(r) * AW'(out_size) + AW'(c);
  endfunction

  // Zero products and off-map coordinates never touch the accumulator.
  for (genvar k = 0; k < lanes; k++) begin : g_lane
    assign lane_hit[k] = (hold_data_q[k] != '0) && (hold_rows_q[k] <= EDGE) && (hold_cols_q[k] <= EDGE);
    assign lane_ext[k] = acc_width'($signed(hold_data_q[k]));
  end

  assign accept      = (state_q == S_ACCUM) && io.in_valid;
  assign raster_last = (row_q == EDGE) && (col_q == EDGE);
  assign raster_addr = addr_of(row_q, col_q);
  assign scat_addr   = addr_of(hold_rows_q[lane_q], hold_cols_q[lane_q]);
  assign col_nx      = (col_q == EDGE) ? '0 : col_q + col_length'(1);
  assign row_nx      = (col_q != EDGE) ? row_q : (raster_last ? '0 : row_q + col_length'(1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lane_d  = lane_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = raster_addr;
    wr_data = '0;
    case (state_q)
      S_CLEAR: begin
        wr_en = 1'b1;
        row_d = row_nx;
        col_d = col_nx;
        if (raster_last) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (io.in_valid) begin
          lane_d  = '0;
          state_d = S_SCATTER;
        end
      end
      S_SCATTER: begin
        if (lane_hit[lane_q]) begin
          wr_en   = 1'b1;
          wr_addr = scat_addr;
          wr_data = acc_q[scat_addr] + lane_ext[lane_q];
        end
        lane_d = lane_q + LW'(1);
        if (lane_q == LAST_LANE) begin
          lane_d  = '0;
          state_d = hold_last_q ? S_DRAIN : S_ACCUM;
        end
      end
      default: begin
        // Drained entries are zeroed on transfer so the next map starts clean.
        if (io.out_ready) begin
          wr_en = 1'b1;
          row_d = row_nx;
          col_d = col_nx;
          if (raster_last) begin
            state_d = S_ACCUM;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) acc_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      row_q       <= '0;
      col_q       <= '0;
      lane_q      <= '0;
      done_q      <= 1'b0;
      hold_data_q <= '0;
      hold_rows_q <= '0;
      hold_cols_q <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lane_q  <= lane_d;
      done_q  <= done_d;
      if (accept) begin
        hold_data_q <= io.data_in;
        hold_rows_q <= io.data_in_rows;
        hold_cols_q <= io.data_in_cols;
        hold_last_q <= io.in_last;
      end
    end
  end

  assign entry = acc_q[raster_addr];
`ifdef PSUM_RELU_EN
  assign drain_val = entry[acc_width-1] ? '0 : entry;
`else
  assign drain_val = entry;
`endif

  assign io.in_ready  = (state_q == S_ACCUM);
  assign io.out_valid = (state_q == S_DRAIN);
  assign io.out_data  = io.out_valid ? drain_val : '0;
  assign io.out_row   = io.out_valid ? row_q : '0;
  assign io.out_col   = io.out_valid ? col_q : '0;
  assign io.done      = done_q;
endmodule

// File: tb/tb_psum_acc.sv
// Bench for psum_acc: table-driven single-beat maps, directed corner sequences and random maps vs a map model.
module tb_psum_acc;
  localparam int WL = 8, CL = 8, LN = 16, OS = 24, AWD = 24, NE = OS*OS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  psum_acc_if #(.word_length(WL), .col_length(CL), .lanes(LN), .acc_width(AWD)) io();
  psum_acc #(.word_length(WL), .col_length(CL), .lanes(LN), .out_size(OS), .acc_width(AWD))
    dut (.clk(clk), .rst(rst), .io(io));

  int checks = 0, failures = 0;
  int model [OS][OS];
  logic [2*WL-1:0] bv [LN];
  logic [CL-1:0]   br [LN], bc [LN];

  typedef struct { int r0, c0, v0, r1, c1, v1, tr, tc, ev, mode; } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected drained word: map sum wrapped to acc width, optionally rectified.
  function automatic int exp_word(input int v);
    logic signed [AWD-1:0] t;
    t = v[AWD-1:0];
`ifdef PSUM_RELU_EN
    if (t < 0) t = '0;
`endif
    return int'(t);
  endfunction

  task automatic clear_beat();
    for (int k = 0; k < LN; k++) begin bv[k] = '0; br[k] = '0; bc[k] = '0; end
  endtask

  task automatic clear_model();
    for (int r = 0; r < OS; r++) for (int c = 0; c < OS; c++) model[r][c] = 0;
  endtask

  task automatic reset_and_check();
    int bad = 0;
    @(negedge clk);
    rst = 1'b1; io.in_valid = 1'b0; io.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < NE; i++) begin
      if (io.in_ready !== 1'b0 || io.out_valid !== 1'b0 || io.done !== 1'b0 ||
          io.out_data !== '0 || io.out_row !== '0 || io.out_col !== '0) bad++;
      @(negedge clk);
    end
    chk("clear_quiet", bad, 0);
    chk("ready_after_clear", io.in_ready, 1);
  endtask

  // Called at a negedge; returns at the negedge after scatter finishes (or right after accept).
  task automatic send_beat(input logic last, input bit lat_chk);
    int w = 0, n = 0;
    for (int k = 0; k < LN; k++) begin
      io.data_in[k*2*WL +: 2*WL]  = bv[k];
      io.data_in_rows[k*CL +: CL] = br[k];
      io.data_in_cols[k*CL +: CL] = bc[k];
    end
    io.in_last = last; io.in_valid = 1'b1;
    while (io.in_ready !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
    chk("accept_wait", (w < 3000), 1);
    if (w >= 3000) begin io.in_valid = 1'b0; return; end
    @(posedge clk);
    for (int k = 0; k < LN; k++)
      if (br[k] < OS && bc[k] < OS) model[br[k]][bc[k]] += int'($signed(bv[k]));
    @(negedge clk);
    io.in_valid = 1'b0; io.in_last = 1'b0;
    if (lat_chk) begin
      while (io.in_ready === 1'b0 && io.out_valid === 1'b0 && n < 40) begin n++; @(negedge clk); end
      chk("scatter_busy", n, LN);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic drain(input int mode, input int tr, input int tc, output int got);
    int n = 0, k = 0, w = 0, bad_done = 0, gap = 0, r, c;
    logic rdy;
    got = -999999;
    while (n < NE && w < 6000) begin
      w++;
      if (io.out_valid === 1'b1) begin
        r = n / OS; c = n % OS;
        chk($sformatf("word%0d_pos", n), io.out_row*256 + io.out_col, r*256 + c);
        chk($sformatf("word%0d_data", n), $signed(io.out_data), exp_word(model[r][c]));
        if (io.done !== 1'b0) bad_done++;
        if (r == tr && c == tc) got = int'($signed(io.out_data));
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'($urandom % 2);
        k++;
        io.out_ready = rdy;
        if (rdy) begin model[r][c] = 0; n++; end
      end else if (n > 0) gap++;
      @(negedge clk);
    end
    io.out_ready = 1'b0;
    chk("drain_gap", gap, 0);
    chk("done_early", bad_done, 0);
    chk("drain_count", n, NE);
    chk("done_pulse", io.done, 1);
    chk("ready_after_drain", io.in_ready, 1);
    @(negedge clk);
    chk("done_clear", io.done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int got, nb;
    io.in_valid = 1'b0; io.in_last = 1'b0; io.out_ready = 1'b0;
    io.data_in = '0; io.data_in_rows = '0; io.data_in_cols = '0;

    tbl[0] = '{r0:0,  c0:0,  v0:5,      r1:30, c1:30, v1:9,     tr:0,  tc:0,  ev:5,      mode:0};
    tbl[1] = '{r0:24, c0:3,  v0:100,    r1:23, c1:23, v1:7,     tr:23, tc:23, ev:7,      mode:0};
    tbl[2] = '{r0:3,  c0:24, v0:50,     r1:5,  c1:5,  v1:-8,    tr:5,  tc:5,  ev:-8,     mode:1};
    tbl[3] = '{r0:4,  c0:4,  v0:-20,    r1:4,  c1:4,  v1:30,    tr:4,  tc:4,  ev:10,     mode:1};
    tbl[4] = '{r0:10, c0:11, v0:32767,  r1:10, c1:11, v1:32767, tr:10, tc:11, ev:65534,  mode:2};
    tbl[5] = '{r0:7,  c0:7,  v0:-32768, r1:0,  c1:0,  v1:0,     tr:7,  tc:7,  ev:-32768, mode:2};
    tbl[6] = '{r0:9,  c0:9,  v0:0,      r1:9,  c1:9,  v1:0,     tr:9,  tc:9,  ev:0,      mode:1};

    reset_and_check();

    clear_beat(); bv[0] = 16'd5;
    send_beat(1'b1, 1'b1);
    drain(0, 0, 0, got);
    chk("single_beat_00", got, 5);

    for (int k = 0; k < LN; k++) begin bv[k] = 16'hFFFD; br[k] = 8'd2; bc[k] = 8'd7; end
    send_beat(1'b0, 1'b1);
    send_beat(1'b1, 1'b1);
    drain(2, 2, 7, got);
    chk("dup_neg_27", got, exp_word(-96));

    for (int i = 0; i < 7; i++) begin
      clear_beat();
      bv[0] = 16'(tbl[i].v0); br[0] = 8'(tbl[i].r0); bc[0] = 8'(tbl[i].c0);
      bv[1] = 16'(tbl[i].v1); br[1] = 8'(tbl[i].r1); bc[1] = 8'(tbl[i].c1);
      send_beat(1'b1, 1'b1);
      drain(tbl[i].mode, tbl[i].tr, tbl[i].tc, got);
      chk($sformatf("vec%0d", i), got, exp_word(tbl[i].ev));
    end

    // 272 contributions of 32767 overflow the 24-bit accumulator and must wrap.
    for (int k = 0; k < LN; k++) begin bv[k] = 16'h7FFF; br[k] = '0; bc[k] = '0; end
    for (int b = 0; b < 17; b++) send_beat(1'(b == 16), 1'b1);
    drain(1, 0, 0, got);
    chk("wrap_00", got, exp_word(17*16*32767));

    for (int m = 0; m < 4; m++) begin
      nb = 1 + int'($urandom % 4);
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < LN; k++) begin
          bv[k] = ($urandom % 4 == 0) ? '0 : 16'($urandom);
          br[k] = 8'($urandom % 26);
          bc[k] = 8'($urandom % 26);
          if ($urandom % 3 == 0) begin br[k] = 8'd5; bc[k] = 8'd6; end
        end
        send_beat(1'(b == nb-1), 1'b1);
      end
      drain(2, -1, -1, got);
    end

    clear_beat();
    for (int k = 0; k < LN; k++) begin bv[k] = 16'(k+1); br[k] = 8'd1; bc[k] = 8'd1; end
    send_beat(1'b0, 1'b0);
    repeat (7) @(negedge clk);
    reset_and_check();
    clear_beat(); bv[0] = 16'd1; br[0] = 8'd1; bc[0] = 8'd1;
    send_beat(1'b1, 1'b1);
    drain(0, 1, 1, got);
    chk("post_reset_11", got, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/psum_acc.md
PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- word_length, 8, operand width; each product is 2*word_length bits, signed
- col_length, 8, row/col coordinate width
- lanes, 16, products per input beat
- out_size, 24, output map edge (image_size-kernel_size+1)
- acc_width, 24, accumulator width, signed
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. One clock; reset is synchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  product beat valid (PE out_valid)
- in_ready  out  1  beat accepted on in_valid&&in_ready
- in_last  in  1  beat is last of output map; sampled with beat
- data_in  in  lanes*2*word_length  signed products, lane k at bits [(k+1)*16-1 -: 16]
- data_in_cols  in  lanes*col_length  column of lane k
- data_in_rows  in  lanes*col_length  row of lane k
- out_valid  out  1  drain word valid
- out_ready  in  1  downstream accepts drain word
- out_data  out  acc_width  accumulated (optionally rectified) value
- out_row  out  col_length  row of out_data
- out_col  out  col_length  column of out_data
- done  out  1  one-cycle pulse, map fully drained

Function
REQ-003 State machine SHALL have states CLEAR, ACCUM, SCATTER, DRAIN.
REQ-004 CLEAR SHALL zero one accumulator entry per cycle in raster order, out_size*out_size cycles, then go to ACCUM; in_ready=0 throughout.
REQ-005 ACCUM SHALL drive in_ready=1; on accept, latch data_in, cols, rows, in_last into a holding register and go to SCATTER with lane index 0.
REQ-006 SCATTER SHALL process one lane per cycle, lane k updating acc[row][col] at edge E0+k+1 (E0 = accept edge); in_ready=0.
REQ-007 A lane SHALL be skipped (no write) when its product is zero or row>=out_size or col>=out_size.
REQ-008 Product SHALL be sign-extended to acc_width and added with two's-complement wrap, no saturation.
REQ-009 Duplicate coordinates within or across beats SHALL accumulate every contribution.
REQ-010 After lane lanes-1, SCATTER SHALL go to DRAIN if latched in_last=1, else ACCUM; peak throughput one beat per lanes+1 cycles.
REQ-011 DRAIN SHALL present entries in raster order (row 0 col 0 first, col fastest) with out_valid=1, holding out_data/out_row/out_col stable until out_valid&&out_ready.
REQ-012 Each transferred entry SHALL be zeroed in the same edge; no separate CLEAR between maps.
REQ-013 After final entry transfers, done SHALL be 1 for exactly the next cycle and the state SHALL return to ACCUM.
REQ-014 in_valid outside ACCUM SHALL be ignored; upstream holds the beat until in_ready.

Reset
REQ-015 rst=1 at any edge, in any state, SHALL enter CLEAR, discard the holding register, and set in_ready=0, out_valid=0, done=0, out_data=0, out_row=0, out_col=0.
REQ-016 Reset mid-SCATTER or mid-DRAIN SHALL lose all partial sums; full CLEAR sequence SHALL complete before next accept.

Configuration
REQ-017 With PSUM_RELU_EN defined, out_data SHALL be 0 when the entry is negative, else the entry; without it, out_data SHALL be the raw signed entry. Accumulator contents SHALL be identical in both builds.

Verification
REQ-018 Reset then idle: rst 1 cycle -> in_ready=0 for 576 cycles, then 1; all outputs 0 throughout.
REQ-019 One beat, lane 0 = +5 at (0,0), others zero, in_last=1 -> in_ready low 16 cycles; drain emits 576 words, (0,0)=5, rest 0; done pulse once.
REQ-020 Two beats, every lane = -3 at (2,7), second with in_last -> drain (2,7)=-96 raw; 0 with PSUM_RELU_EN.
REQ-021 Lane at (24,3) value 100 plus lane at (23,23) value 7 -> out-of-range dropped; (23,23)=7 is word 575, last drained.
REQ-022 out_ready toggled 1,0,0,1 during drain -> each word held while stalled, no word lost or duplicated; second map after done starts from zero.
REQ-023 rst asserted at lane 8 of SCATTER -> CLEAR restarts; later single beat +1 at (1,1) drains (1,1)=1 only.
